// File: rtl/inner_prod_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inner_prod_pkg
// Purpose  : Shared constants, width helpers and state type for the streaming
//            inner-product block.
// Contents : DEF_DATA_W / DEF_VEC_LEN default parameters, clog2(), out_width()
//            and the two-state controller enum state_t.
// Revision : 1.0 - initial release
// ============================================================================
package inner_prod_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_VEC_LEN = 8;

    // Ceiling log2; clog2(1) = 0, clog2(8) = 3, clog2(9) = 4.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Accumulator/result width: a full-precision product plus enough guard
    // bits to sum VEC_LEN of them without overflow in either mode.
    function automatic int out_width(input int data_w, input int vec_len);
        return 2 * data_w + clog2(vec_len);
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/inner_prod_mac.sv
`default_nettype none
// ============================================================================
// Module   : inner_prod_mac
// Purpose  : Combinational product of one A/B element pair, extended to the
//            accumulator width according to the operand mode.
// Ports    : i_a, i_b       [DATA_W-1:0]  operands
//            i_signed_mode                1 = two's complement, 0 = unsigned
//            o_prod_ext     [OUT_W-1:0]   product, sign/zero-extended
// Revision : 1.0 - initial release
// ============================================================================
module inner_prod_mac
    import inner_prod_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = 2 * DEF_DATA_W + 1
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_signed_mode,
    output logic [OUT_W-1:0]  o_prod_ext
);

    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;
    logic              w_ext_bit;

    // Operands are widened to the product width first (sign or zero fill),
    // so one unsigned multiplier truncated to PROD_W bits yields the exact
    // product in both modes.
    always_comb begin
        w_a_ext    = {{DATA_W{i_signed_mode & i_a[DATA_W-1]}}, i_a};
        w_b_ext    = {{DATA_W{i_signed_mode & i_b[DATA_W-1]}}, i_b};
        w_prod     = w_a_ext * w_b_ext;
        w_ext_bit  = i_signed_mode & w_prod[PROD_W-1];
        o_prod_ext = {{(OUT_W - PROD_W){w_ext_bit}}, w_prod};
    end

endmodule
`default_nettype wire

// File: rtl/inner_prod_stream.sv
`default_nettype none
// ============================================================================
// Module   : inner_prod_stream
// Purpose  : Streaming inner product of two VEC_LEN-element vectors received
//            one element pair per accepted cycle; the result is presented on
//            a valid/ready output register.
// Ports    : clk, rst (async, active low)
//            valid_in / ready_in, signed_mode, clr, A, B  - element input
//            valid_out / ready_out, C [OUT_W-1:0]         - result output
// Revision : 1.0 - initial release
// ============================================================================
module inner_prod_stream
    import inner_prod_pkg::*;
#(
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int VEC_LEN = DEF_VEC_LEN,
    localparam int OUT_W   = out_width(DATA_W, VEC_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              signed_mode,
    input  logic              clr,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [OUT_W-1:0]  C
);

    localparam int                CNT_W    = clog2(VEC_LEN);
    localparam logic [CNT_W-1:0]  C_LAST   = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0]  C_CNT_1  = CNT_W'(1);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [OUT_W-1:0]   acc_q,       acc_d;
    logic               mode_q,      mode_d;
    logic [OUT_W-1:0]   c_q,         c_d;
    logic               valid_out_q, valid_out_d;

    logic               w_last;
    logic               w_accept;
    logic               w_mode;
    logic [OUT_W-1:0]   w_prod;

    assign w_last   = (cnt_q == C_LAST);
    // Only the final element needs a free output register; earlier elements
    // of the next vector flow in while a result is still waiting.
    assign ready_in = ~(w_last & valid_out_q & ~ready_out);
    assign w_accept = valid_in & ready_in;
    // Element 0 uses the live mode input; the rest of the vector uses the
    // value latched with element 0.
    assign w_mode   = (state_q == ST_IDLE) ? signed_mode : mode_q;

    inner_prod_mac #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_mac (
        .i_a           (A),
        .i_b           (B),
        .i_signed_mode (w_mode),
        .o_prod_ext    (w_prod)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        c_d         = c_q;
        valid_out_d = valid_out_q & ~ready_out;

        if (clr) begin
            // Abort wins over a simultaneous element; the output side is
            // left untouched.
            state_d = ST_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (w_accept) begin
            if (state_q == ST_IDLE) begin
                mode_d = signed_mode;
            end
            if (w_last) begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                acc_d       = '0;
                c_d         = acc_q + w_prod;
                valid_out_d = 1'b1;
            end else begin
                state_d = ST_ACC;
                cnt_d   = cnt_q + C_CNT_1;
                acc_d   = acc_q + w_prod;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mode_q      <= 1'b0;
            c_q         <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            c_q         <= c_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign C         = c_q;
    assign valid_out = valid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_inner_prod_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_inner_prod_stream
// Purpose  : Self-checking bench for inner_prod_stream. A driver issues
//            vectors and pushes the expected inner product into a queue; an
//            independent monitor pops and compares on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inner_prod_stream;

    localparam int DW = 8;
    localparam int VL = 8;
    localparam int OW = 19;

    typedef logic [DW-1:0] vec_t [VL];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic          signed_mode = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] A = '0;
    logic [DW-1:0] B = '0;
    logic          valid_out;
    logic          ready_out = 1'b1;
    logic [OW-1:0] C;

    int            total = 0;
    int            bad   = 0;
    int            ro_mode = 0;   // 0: always ready, 1: random, 2: held low
    logic [OW-1:0] exp_q [$];

    vec_t dir_a, dir_b, ff_v, v80;

    inner_prod_stream dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .signed_mode (signed_mode),
        .clr         (clr),
        .A           (A),
        .B           (B),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .C           (C)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h required=%h", nm, got, exp);
        end
    endtask

    // Reference: plain integer sum of element products in the vector's mode.
    function automatic logic [OW-1:0] model(input vec_t av, input vec_t bv, input bit m);
        longint s, x, y;
        logic [63:0] r;
        s = 0;
        for (int i = 0; i < VL; i++) begin
            x = m ? longint'($signed(av[i])) : longint'(av[i]);
            y = m ? longint'($signed(bv[i])) : longint'(bv[i]);
            s = s + x * y;
        end
        r = s;
        return r[OW-1:0];
    endfunction

    // Downstream ready generator.
    initial begin
        forever begin
            @(negedge clk);
            case (ro_mode)
                0:       ready_out = 1'b1;
                1:       ready_out = 1'($urandom_range(1));
                default: ready_out = 1'b0;
            endcase
        end
    end

    // Monitor: a transfer happens at the next rising edge when both are high.
    initial begin
        logic [OW-1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rst && valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result C=%h required=none", C);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_C", 32'(C), 32'(e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic send_elem(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic sm, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        while (!done && waits < 200) begin
            @(negedge clk);
            valid_in    = 1'b1;
            A           = a;
            B           = b;
            signed_mode = sm;
            clr         = 1'b0;
            #1;
            if (ready_in) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout ready_in=%b required=1", ready_in);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        valid_in    = 1'b0;
        clr         = 1'b0;
        A           = DW'($urandom);
        B           = DW'($urandom);
        signed_mode = 1'($urandom_range(1));
        @(posedge clk);
    endtask

    // Let a result drain with ready_out=1 and confirm valid_out drops.
    task automatic settle();
        idle_cycle();
        #1;
        chk("valid_one_cycle", 32'(valid_out), 32'd0);
    endtask

    task automatic send_partial(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            send_elem(DW'($urandom), DW'($urandom), 1'($urandom_range(1)), w);
        end
    endtask

    task automatic clr_cycle();
        @(negedge clk);
        valid_in = 1'b1;
        A        = DW'($urandom);
        B        = DW'($urandom);
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        valid_in = 1'b0;
    endtask

    // exp_in < 0 selects the reference model; otherwise a fixed expectation.
    task automatic send_vector(input vec_t av, input vec_t bv, input bit m0,
                               input bit toggle, input int gap_pct, input int exp_in);
        logic [OW-1:0] e;
        logic [31:0]   ei;
        logic          sm;
        int            w;
        ei = exp_in;
        e  = (exp_in < 0) ? model(av, bv, m0) : ei[OW-1:0];
        exp_q.push_back(e);
        for (int i = 0; i < VL; i++) begin
            if (i > 0 && $urandom_range(99) < gap_pct) idle_cycle();
            sm = (i == 0) ? m0 : (toggle ? 1'($urandom_range(1)) : m0);
            send_elem(av[i], bv[i], sm, w);
        end
        #1;
        chk("load_valid", 32'(valid_out), 32'd1);
        chk("load_C", 32'(C), 32'(e));
        valid_in = 1'b0;
    endtask

    initial begin
        int   w, wsum;
        vec_t ra, rb;

        dir_a = '{8'h01, 8'hB2, 8'h31, 8'h15, 8'hE3, 8'hD0, 8'hFF, 8'hCB};
        dir_b = '{8'h3D, 8'h15, 8'h99, 8'hA6, 8'h72, 8'h5B, 8'h4E, 8'h53};
        for (int i = 0; i < VL; i++) begin
            ff_v[i] = 8'hFF;
            v80[i]  = 8'h80;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_C", 32'(C), 32'd0);
        chk("reset_valid_out", 32'(valid_out), 32'd0);
        chk("reset_ready_in", 32'(ready_in), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors, unsigned and signed (mode toggled mid-vector)
        send_vector(dir_a, dir_b, 1'b0, 1'b0, 0, 32'h17847);
        settle();
        send_vector(dir_a, dir_b, 1'b1, 1'b0, 0, 32'h7AF47);
        settle();
        send_vector(dir_a, dir_b, 1'b1, 1'b1, 0, 32'h7AF47);
        settle();

        // Extremes
        send_vector(ff_v, ff_v, 1'b0, 1'b0, 0, 32'h7F008);
        settle();
        send_vector(v80, v80, 1'b1, 1'b0, 0, 32'h20000);
        settle();

        // Backpressure: second vector stalls only on its last element
        ro_mode = 2;
        send_vector(dir_a, dir_b, 1'b0, 1'b0, 0, 32'h17847);
        exp_q.push_back(19'h7AF47);
        wsum = 0;
        for (int i = 0; i < VL - 1; i++) begin
            send_elem(dir_a[i], dir_b[i], 1'b1, w);
            wsum += w;
        end
        chk("no_stall_before_last", 32'(wsum), 32'd0);
        repeat (3) begin
            @(negedge clk);
            valid_in    = 1'b1;
            A           = dir_a[VL-1];
            B           = dir_b[VL-1];
            signed_mode = 1'b0;
            #1;
            chk("stall_ready_in", 32'(ready_in), 32'd0);
            chk("held_C", 32'(C), 32'h17847);
            chk("held_valid_out", 32'(valid_out), 32'd1);
        end
        ro_mode = 0;
        send_elem(dir_a[VL-1], dir_b[VL-1], 1'b0, w);
        #1;
        chk("second_load_valid", 32'(valid_out), 32'd1);
        chk("second_load_C", 32'(C), 32'h7AF47);
        valid_in = 1'b0;
        settle();

        // Abort at element 4, then a fresh vector; then a gapped vector
        send_partial(4);
        clr_cycle();
        chk("clr_keeps_C", 32'(C), 32'h7AF47);
        chk("clr_keeps_valid", 32'(valid_out), 32'd0);
        send_vector(dir_a, dir_b, 1'b0, 1'b0, 0, 32'h17847);
        settle();
        send_vector(dir_a, dir_b, 1'b0, 1'b0, 60, 32'h17847);
        settle();

        // Asynchronous reset with a pending result and a partial vector
        ro_mode = 2;
        send_vector(ff_v, ff_v, 1'b0, 1'b0, 0, 32'h7F008);
        send_partial(5);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_C", 32'(C), 32'd0);
        chk("async_rst_valid", 32'(valid_out), 32'd0);
        valid_in = 1'b0;
        exp_q.delete();
        ro_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        send_vector(dir_a, dir_b, 1'b1, 1'b1, 0, 32'h7AF47);
        settle();

        // Randomized traffic with random backpressure, gaps and aborts
        ro_mode = 1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(4) == 0) begin
                send_partial(int'($urandom_range(6, 1)));
                clr_cycle();
            end
            for (int i = 0; i < VL; i++) begin
                ra[i] = DW'($urandom);
                rb[i] = DW'($urandom);
            end
            send_vector(ra, rb, 1'($urandom_range(1)), 1'b1, 30, -1);
        end

        // Drain outstanding results
        ro_mode = 0;
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) idle_cycle();
        repeat (2) idle_cycle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inner_prod_stream.md
INNER_PROD_STREAM -- requirements
Module: inner_prod_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, element width of A and B.
REQ-002 SHALL have parameter VEC_LEN, default 8, elements per vector; legal range 2..256.
REQ-003 SHALL have derived constant OUT_W = 2*DATA_W + clog2(VEC_LEN), default 19.
REQ-004 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port valid_in  input  1  A/B/signed_mode valid this cycle.
REQ-007 SHALL have port ready_in  output  1  block accepts an element this cycle.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port clr  input  1  synchronous abort of the partial vector.
REQ-010 SHALL have port A  input  DATA_W  element of vector A.
REQ-011 SHALL have port B  input  DATA_W  element of vector B.
REQ-012 SHALL have port valid_out  output  1  C holds a completed inner product.
REQ-013 SHALL have port ready_out  input  1  downstream accepts C.
REQ-014 SHALL have port C  output  OUT_W  inner product, sign-extended in signed mode.

Function
REQ-015 SHALL accept an element only on a rising edge with valid_in=1 and ready_in=1.
REQ-016 SHALL keep an element counter 0..VEC_LEN-1 that wraps to 0 after the last accepted element.
REQ-017 SHALL use two states, IDLE (counter=0) and ACC (counter>0); IDLE->ACC on acceptance, ACC->IDLE on acceptance of element VEC_LEN-1 or on clr.
REQ-018 SHALL sample signed_mode only with element 0 and hold that value for the rest of the vector; changes in mid-vector SHALL be ignored.
REQ-019 SHALL form each product at 2*DATA_W bits, then extend it to OUT_W bits (sign-extend if signed, zero-extend if unsigned) before accumulating; no overflow is possible.
REQ-020 SHALL load accumulator+last product into C and set valid_out on the same edge that accepts element VEC_LEN-1, giving a result one cycle after the last element.
REQ-021 SHALL hold C and valid_out stable until a cycle with ready_out=1; valid_out SHALL then clear, unless a new result loads on that same edge.
REQ-022 SHALL let valid_out stay high for exactly one cycle per result when ready_out is held at 1.
REQ-023 SHALL accept the next vector's elements 0..VEC_LEN-2 while an earlier result waits.
REQ-024 SHALL drive ready_in = NOT(counter=VEC_LEN-1 AND valid_out AND NOT ready_out), so the last element stalls only while an unaccepted result is pending (combinational path from ready_out).
REQ-025 SHALL let clr zero the counter and accumulator without affecting C/valid_out; clr overrides an element on the same edge, and that element SHALL be dropped.
REQ-026 SHALL, for idle cycles (valid_in=0) inside a vector, keep the counter and accumulator unchanged.

Reset
REQ-027 SHALL, on rst=0, immediately set C=0, valid_out=0, counter=0, accumulator=0, latched mode=0, state IDLE, regardless of clk.
REQ-028 SHALL discard any partial vector or pending result after a reset in mid-operation; the first vector after release starts at element 0.

Structure
REQ-029 SHALL take clog2, default DATA_W/VEC_LEN and the OUT_W derivation from shared package inner_prod_pkg.
REQ-030 SHALL place product forming and extension to OUT_W in one sub-module, inner_prod_mac (combinational, mode input).

Verification
REQ-031 Default params, unsigned, A=01,B2,31,15,E3,D0,FF,CB, B=3D,15,99,A6,72,5B,4E,53 back-to-back, ready_out=1 -> C=19'h17847 with valid_out high exactly one cycle, one cycle after the last element.
REQ-032 Same vectors with signed_mode=1 on element 0 -> C=19'h7AF47 (-20665); toggling signed_mode on elements 1..7 -> same result.
REQ-033 Extremes: all A=B=FF unsigned -> C=19'h7F008; all A=B=80 signed -> C=19'h20000.
REQ-034 Two vectors back-to-back with ready_out=0 -> ready_in low only at the second vector's element 7; after ready_out=1 for one cycle, first C is accepted, second vector completes and gives its correct C.
REQ-035 clr asserted at element 4, then full vector -> C equals the product of the new vector only; gaps of valid_in=0 inside a vector -> result unchanged.
REQ-036 rst=0 asserted between clock edges at element 5 and with a result pending -> C=0 and valid_out=0 at once; the next full vector gives the correct result.
